gene_net_sequencer: RTL and testbench

Hardware sequencer for the 8-bit gene-network state-update datapath and its fixed-point and cycle checkers.
- Loads a seed state into the network and feeds each `next_status` back as the following `status`.
- Clears the checkers at the start of every run and stops on fixed point, cycle, or step budget.
- Reports the final state, step count and result code with a start/busy/done handshake.
- Replaces hand-driven iteration and sits between the control software/bench and the network.

---
 rtl/gene_net_seq_pkg.sv | 23 ++
 rtl/gene_net_sequencer.sv | 108 ++++++++++
 tb/tb_gene_net_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gene_net_seq_pkg.sv
// Shared definitions for the gene-network sequencer: FSM state encoding,
// result codes, default sizes and the latency-timer width helper.
package gene_net_seq_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_STEPS = 10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_APPLY  = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [1:0] RES_TIMEOUT = 2'b00;
  localparam logic [1:0] RES_FIXED   = 2'b01;
  localparam logic [1:0] RES_CYCLE   = 2'b10;

  // Timer must hold NET_LAT-1; keep at least one bit when NET_LAT == 1.
  function automatic int tmr_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/gene_net_sequencer.sv
// Gene-network sequencer: seeds the network, iterates next_status back into
// status, stops on fixed point / cycle / step budget and reports the outcome.
// Optional macro GNSEQ_SINGLE_STEP_EN adds a step_en input that gates each
// APPLY->SAMPLE transition so a debugger can stall between iterations.
module gene_net_sequencer
  import gene_net_seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_STEPS = DEF_MAX_STEPS,
  parameter int NET_LAT   = 1,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] net_status,
  input  logic [WIDTH-1:0] net_next,
  output logic             chk_reset,
  input  logic             is_fixed,
  input  logic             is_cycle,
`ifdef GNSEQ_SINGLE_STEP_EN
  input  logic             step_en,
`endif
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic [WIDTH-1:0] final_status,
  output logic [CNT_W-1:0] steps
);

  localparam int             TW     = tmr_w(NET_LAT);
  localparam logic [TW-1:0]  LAT_M1 = TW'(NET_LAT - 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

  logic [2:0]       state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] steps_inc;
  logic             adv;

  assign steps_inc = steps + 1'b1;

`ifdef GNSEQ_SINGLE_STEP_EN
  assign adv = (timer == '0) && step_en;
`else
  assign adv = (timer == '0);
`endif

  // Handshake and checker clear decode straight from the state so that an
  // asynchronous reset is visible on them in the same cycle.
  always_comb begin
    chk_reset = (state == ST_IDLE) || (state == ST_CLEAR);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
  end

  // Sequencer FSM with latency timer, step counter and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      timer        <= '0;
      net_status   <= '0;
      final_status <= '0;
      steps        <= '0;
      result       <= RES_TIMEOUT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            net_status <= seed;
            steps      <= '0;
            state      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          timer <= LAT_M1;
          state <= ST_APPLY;
        end
        ST_APPLY: begin
          if (adv)              state <= ST_SAMPLE;
          else if (timer != '0) timer <= timer - 1'b1;
        end
        ST_SAMPLE: begin
          net_status   <= net_next;
          final_status <= net_next;
          steps        <= steps_inc;
          // Fixed point outranks cycle; the budget only matters if neither hit.
          if (is_fixed) begin
            result <= RES_FIXED;
            state  <= ST_DONE;
          end else if (is_cycle) begin
            result <= RES_CYCLE;
            state  <= ST_DONE;
          end else if (steps_inc == MAX_C) begin
            result <= RES_TIMEOUT;
            state  <= ST_DONE;
          end else begin
            timer <= LAT_M1;
            state <= ST_APPLY;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gene_net_sequencer.sv
// Self-checking bench for gene_net_sequencer: stub network + checkers, a
// run-level reference model, and a per-cycle compare process.
module tb_gene_net_sequencer;

  localparam int W  = 8;
  localparam int MS = 10;
  localparam int L  = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  seed = '0;
  logic [W-1:0]  net_status, net_next, final_status;
  logic          chk_reset, is_fixed, is_cycle, busy, done;
  logic [1:0]    result;
  logic [CW-1:0] steps;

  gene_net_sequencer #(.WIDTH(W), .MAX_STEPS(MS), .NET_LAT(L), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .net_status(net_status), .net_next(net_next), .chk_reset(chk_reset),
    .is_fixed(is_fixed), .is_cycle(is_cycle), .busy(busy), .done(done),
    .result(result), .final_status(final_status), .steps(steps));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Network personality: 0 identity/fixed, 1 rotate/cycle-to-seed,
  // 2 increment/no flags, 3 identity with both flags, 4 random tables.
  int         mode = 0;
  logic [7:0] run_seed = '0;
  logic [7:0] nxt_tab [256];
  bit         fx_tab  [256];
  bit         cy_tab  [256];

  // Stub network and checkers (combinational, so NET_LAT = 1 suffices).
  always_comb begin
    net_next = net_status;
    is_fixed = 1'b0;
    is_cycle = 1'b0;
    case (mode)
      0: begin net_next = net_status; is_fixed = 1'b1; end
      1: begin
        net_next = {net_status[6:0], net_status[7]};
        is_cycle = ({net_status[6:0], net_status[7]} == run_seed);
      end
      2: net_next = net_status + 8'd1;
      3: begin net_next = net_status; is_fixed = 1'b1; is_cycle = 1'b1; end
      default: begin
        net_next = nxt_tab[net_status];
        is_fixed = fx_tab[net_status];
        is_cycle = cy_tab[net_status];
      end
    endcase
  end

  // Reference model, from the run rules: list of visited states, step count,
  // outcome and the cycle of the done pulse.
  function automatic logic [7:0] m_next(input logic [7:0] s);
    case (mode)
      1:       return {s[6:0], s[7]};
      2:       return s + 8'd1;
      4:       return nxt_tab[s];
      default: return s;
    endcase
  endfunction
  function automatic bit m_fix(input logic [7:0] s, input logic [7:0] n);
    case (mode)
      0:       return n == s;
      3:       return 1'b1;
      4:       return fx_tab[s];
      default: return 1'b0;
    endcase
  endfunction
  function automatic bit m_cyc(input logic [7:0] s, input logic [7:0] n);
    case (mode)
      1:       return n == run_seed;
      3:       return 1'b1;
      4:       return cy_tab[s];
      default: return 1'b0;
    endcase
  endfunction

  logic [7:0] exp_seq[$];
  int         exp_S;
  logic [1:0] exp_res;
  int         exp_D;

  task automatic build_model(input logic [7:0] sd);
    logic [7:0] s, n;
    bit fin;
    exp_seq = {};
    exp_seq.push_back(sd);
    s = sd; fin = 0;
    for (int k = 1; k <= MS && !fin; k++) begin
      n = m_next(s);
      exp_seq.push_back(n);
      exp_S = k;
      fin = 1;
      if (m_fix(s, n))      exp_res = 2'b01;
      else if (m_cyc(s, n)) exp_res = 2'b10;
      else if (k == MS)     exp_res = 2'b00;
      else                  fin = 0;
      s = n;
    end
    exp_D = 2 + (L + 1) * exp_S;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare process state.
  logic       start_at_edge = 1'b0;
  int         active = 0, skip = 0, run_cyc = 0, runs_done = 0;
  logic [1:0] last_res = '0;
  logic [7:0] last_final = '0;
  int         last_steps = 0;
  int         obs_D = -1, obs_steps = -1;
  logic [1:0] obs_res = '0;
  logic [7:0] obs_final = '0;

  always @(posedge clk) start_at_edge <= start;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int k;
    if (!reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_chk_reset", chk_reset, 1);
      chk("rst_net_status", net_status, 0);
      chk("rst_result", result, 0);
      chk("rst_final", final_status, 0);
      chk("rst_steps", steps, 0);
      active = 0; skip = 0;
      last_res = '0; last_final = '0; last_steps = 0;
    end else begin
      if (!active && !skip && start_at_edge) begin
        active = 1; run_cyc = 0; obs_D = -1; obs_steps = -1;
      end
      skip = 0;
      if (active) begin
        run_cyc++;
        k = (run_cyc < 2) ? 0 : (run_cyc - 2) / (L + 1);
        if (k > exp_S) k = exp_S;
        if (done && obs_D < 0) begin
          obs_D = run_cyc; obs_res = result; obs_steps = int'(steps); obs_final = final_status;
        end
        chk("run_busy", busy, 1);
        chk("run_done", done, run_cyc == exp_D);
        chk("run_chk_reset", chk_reset, run_cyc == 1);
        chk("run_net_status", net_status, exp_seq[k]);
        chk("run_steps", steps, k);
        chk("run_final", final_status, (k >= 1) ? exp_seq[k] : last_final);
        chk("run_result", result, (run_cyc == exp_D) ? exp_res : last_res);
        if (run_cyc == exp_D) begin
          last_res = exp_res; last_final = exp_seq[exp_S]; last_steps = exp_S;
          active = 0; skip = 1; runs_done++;
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_chk_reset", chk_reset, 1);
        chk("idle_net_status", net_status, last_final);
        chk("idle_result", result, last_res);
        chk("idle_final", final_status, last_final);
        chk("idle_steps", steps, last_steps);
      end
    end
  end

  task automatic wait_runs(input int target);
    for (int i = 0; i < 400 && runs_done < target; i++) @(posedge clk);
    chk("run_completes", runs_done >= target, 1);
  endtask

  // One run; glitch pulses start with seed FF partway through.
  task automatic do_run(input int md, input logic [7:0] sd, input bit glitch);
    int n0;
    @(posedge clk); #1;
    mode = md; run_seed = sd; seed = sd;
    build_model(sd);
    n0 = runs_done;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (glitch) begin
      repeat (3) @(posedge clk);
      #1 seed = 8'hFF; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_runs(n0 + 1);
  endtask

  task automatic pin(input string nm, input int d, input logic [1:0] r,
                     input int s, input logic [7:0] f);
    if (d >= 0) chk({nm, "_done_cycle"}, obs_D, d);
    chk({nm, "_result"}, obs_res, r);
    chk({nm, "_steps"}, obs_steps, s);
    chk({nm, "_final"}, obs_final, f);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    do_run(0, 8'h00, 0); pin("t1_fixed", 4, 2'b01, 1, 8'h00);
    do_run(1, 8'h0F, 0); pin("t2_cycle", 18, 2'b10, 8, 8'h0F);
    do_run(2, 8'hAA, 0); pin("t3_timeout", 22, 2'b00, 10, 8'hB4);
    do_run(2, 8'hAA, 1); pin("t4_ignored_start", 22, 2'b00, 10, 8'hB4);
    do_run(3, 8'h3C, 0); pin("t6_both_flags", 4, 2'b01, 1, 8'h3C);

    // Start held high: second run begins in the first IDLE cycle after DONE.
    @(posedge clk); #1;
    mode = 1; run_seed = 8'h81; seed = 8'h81; build_model(8'h81);
    n0 = runs_done; start = 1'b1;
    wait_runs(n0 + 2);
    #1 start = 1'b0;
    pin("held_start", 18, 2'b10, 8, 8'h81);

    // Reset in the middle of an APPLY cycle.
    @(posedge clk); #1;
    mode = 2; run_seed = 8'h10; seed = 8'h10; build_model(8'h10);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_net_status", net_status, 0);
    chk("t5_chk_reset", chk_reset, 1);
    chk("t5_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    do_run(2, 8'h55, 0); pin("t5_after_reset", 22, 2'b00, 10, 8'h5F);

    // Randomized runs over all network personalities.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 256; i++) begin
        nxt_tab[i] = 8'($urandom);
        fx_tab[i]  = ($urandom_range(0, 9) == 0);
        cy_tab[i]  = ($urandom_range(0, 9) == 0);
      end
      do_run($urandom_range(0, 4), 8'($urandom), $urandom_range(0, 3) == 0);
      pin("rand", exp_D, exp_res, exp_S, exp_seq[exp_S]);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
